// File: rtl/tartaruga_pkg.sv
// ----------------------------------------------------------------------------
// tartaruga_pkg
// Shared types and constants for the tartaruga MEM stage.
//   SB_DEPTH           default number of store buffer entries (power of two)
//   IDX_W              width of a store buffer index
//   bus32_t            32-bit data/address word
//   store_buffer_idx_t store buffer entry index
//   sb_entry_t         one store buffer entry: valid, committed, addr, data
// ----------------------------------------------------------------------------
package tartaruga_pkg;

  localparam int SB_DEPTH = 4;
  localparam int IDX_W    = $clog2(SB_DEPTH);

  typedef logic [31:0]      bus32_t;
  typedef logic [IDX_W-1:0] store_buffer_idx_t;

  typedef struct packed {
    logic   valid;
    logic   committed;
    bus32_t addr;
    bus32_t data;
  } sb_entry_t;

endpackage

// File: rtl/tarta_store_buffer.sv
// ----------------------------------------------------------------------------
// tarta_store_buffer
// In-order circular store buffer sitting in the MEM stage between EXE stores
// and the dcache write port. Stores are allocated speculatively at the tail,
// marked committed by writeback (by index), and drained from the head to the
// dcache once committed. Younger loads get the data of the youngest buffered
// store to the same 32-bit word.
//
// Ports
//   clk_i, rstn_i                 clock, asynchronous active-low reset
//   data_i, addr_i                store data / store-or-load address
//   load_i                        load in MEM: request forwarding
//   bypass_o, data_rd_o           forwarding hit and forwarded data
//   req_valid_i, req_ready_o      store allocation handshake
//   rsp_valid_o, rsp_ready_i      dcache write handshake for the head entry
//   addr_o, data_wr_o             head entry address/data (0 when not valid)
//   store_buffer_idx_o            index the current store lands in (tail)
//   store_buffer_commit_i         commit pulse for store_buffer_idx_commit_i
//   store_buffer_discard_i        drop every uncommitted entry
// ----------------------------------------------------------------------------
module tarta_store_buffer
  import tartaruga_pkg::*;
#(
  parameter int SB_DEPTH = tartaruga_pkg::SB_DEPTH,
  parameter int IDX_W    = $clog2(SB_DEPTH)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [31:0]      data_i,
  input  logic [31:0]      addr_i,
  input  logic             load_i,
  output logic             bypass_o,
  output logic [31:0]      data_rd_o,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      addr_o,
  output logic [31:0]      data_wr_o,
  output logic [IDX_W-1:0] store_buffer_idx_o,
  input  logic             store_buffer_commit_i,
  input  logic [IDX_W-1:0] store_buffer_idx_commit_i,
  input  logic             store_buffer_discard_i
);

  localparam logic [IDX_W:0]   FULL_CNT = (IDX_W+1)'(SB_DEPTH);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  sb_entry_t        entries_q [SB_DEPTH];
  sb_entry_t        entries_d [SB_DEPTH];
  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d;

  logic             alloc;
  logic             pop;
  logic             head_ready;
  logic [32:0]      fwd;

  // Youngest matching store: walk from tail-1 backwards. Only live entries
  // are valid, so a full lap visits exactly the entries between head and tail
  // in youngest-first order.
  function automatic logic [32:0] youngest_match(
    input sb_entry_t        ents [SB_DEPTH],
    input logic [IDX_W-1:0] tail,
    input bus32_t           addr
  );
    logic [32:0]      res;
    logic [IDX_W-1:0] k;
    logic             found;
    res   = '0;
    found = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      k = tail - IDX_W'(i + 1);
      if (!found && ents[k].valid && (ents[k].addr[31:2] == addr[31:2])) begin
        found = 1'b1;
        res   = {1'b1, ents[k].data};
      end
    end
    return res;
  endfunction

  // No pass-through when full: a same-cycle pop does not free a slot early.
  assign req_ready_o = (count_q != FULL_CNT) && !store_buffer_discard_i;
  assign alloc       = req_valid_i && req_ready_o;

  assign head_ready  = entries_q[head_q].valid && entries_q[head_q].committed;
  assign rsp_valid_o = head_ready;
  assign pop         = head_ready && rsp_ready_i;
  assign addr_o      = head_ready ? entries_q[head_q].addr : 32'h0;
  assign data_wr_o   = head_ready ? entries_q[head_q].data : 32'h0;

  assign store_buffer_idx_o = tail_q;

  // Forwarding looks at registered state only, so a store allocated this
  // cycle becomes visible to loads from the next cycle on.
  assign fwd       = youngest_match(entries_q, tail_q, addr_i);
  assign bypass_o  = load_i && fwd[32];
  assign data_rd_o = (load_i && fwd[32]) ? fwd[31:0] : 32'h0;

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] k;
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = '0;
    found     = 1'b0;
    k         = '0;

    // Commit first so that a commit landing together with a discard keeps
    // its entry.
    if (store_buffer_commit_i && entries_q[store_buffer_idx_commit_i].valid) begin
      entries_d[store_buffer_idx_commit_i].committed = 1'b1;
    end

    if (pop) begin
      entries_d[head_q].valid     = 1'b0;
      entries_d[head_q].committed = 1'b0;
      head_d                      = head_q + IDX_ONE;
    end

    // alloc is never set during a discard (req_ready_o is low then).
    if (alloc) begin
      entries_d[tail_q].valid     = 1'b1;
      entries_d[tail_q].committed = 1'b0;
      entries_d[tail_q].addr      = addr_i;
      entries_d[tail_q].data      = data_i;
      tail_d                      = tail_q + IDX_ONE;
    end

    if (store_buffer_discard_i) begin
      // Committed entries form a prefix from head, so the oldest uncommitted
      // live entry is where the tail rewinds to.
      for (int i = 0; i < SB_DEPTH; i++) begin
        k = head_q + IDX_W'(i);
        if (!found && entries_d[k].valid && !entries_d[k].committed) begin
          found  = 1'b1;
          tail_d = k;
        end
      end
      for (int i = 0; i < SB_DEPTH; i++) begin
        if (entries_d[i].valid && !entries_d[i].committed) begin
          entries_d[i].valid = 1'b0;
        end
      end
    end

    // Occupancy is re-derived from the valid bits; this covers allocate,
    // pop, simultaneous allocate+pop and discard uniformly.
    for (int i = 0; i < SB_DEPTH; i++) begin
      count_d = count_d + (IDX_W+1)'(entries_d[i].valid);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < SB_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
          entries_q[gi] <= '0;
        end else begin
          entries_q[gi] <= entries_d[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_tarta_store_buffer.sv
module tb_tarta_store_buffer;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic [31:0] data_i;
  logic [31:0] addr_i;
  logic        load_i;
  logic        bypass_o;
  logic [31:0] data_rd_o;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] addr_o;
  logic [31:0] data_wr_o;
  logic [1:0]  store_buffer_idx_o;
  logic        store_buffer_commit_i;
  logic [1:0]  store_buffer_idx_commit_i;
  logic        store_buffer_discard_i;

  int checks = 0;
  int errors = 0;

  tarta_store_buffer #(.SB_DEPTH(4), .IDX_W(2)) dut (
    .clk_i                     (clk_i),
    .rstn_i                    (rstn_i),
    .data_i                    (data_i),
    .addr_i                    (addr_i),
    .load_i                    (load_i),
    .bypass_o                  (bypass_o),
    .data_rd_o                 (data_rd_o),
    .req_valid_i               (req_valid_i),
    .req_ready_o               (req_ready_o),
    .rsp_valid_o               (rsp_valid_o),
    .rsp_ready_i               (rsp_ready_i),
    .addr_o                    (addr_o),
    .data_wr_o                 (data_wr_o),
    .store_buffer_idx_o        (store_buffer_idx_o),
    .store_buffer_commit_i     (store_buffer_commit_i),
    .store_buffer_idx_commit_i (store_buffer_idx_commit_i),
    .store_buffer_discard_i    (store_buffer_discard_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic idle_inputs();
    data_i = '0; addr_i = '0; load_i = 0; req_valid_i = 0; rsp_ready_i = 0;
    store_buffer_commit_i = 0; store_buffer_idx_commit_i = '0; store_buffer_discard_i = 0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    req_valid_i = 1; addr_i = a; data_i = d;
    tick();
    req_valid_i = 0;
    $display("store addr=%08h data=%08h", a, d);
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn_i = 0;
    repeat (2) @(posedge clk_i);
    #1 rstn_i = 1;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn_i = 0;
    load_i = 1; addr_i = 32'h0;
    #3;
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", req_ready_o); end
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0b want 0", rsp_valid_o); end
    checks++; if (bypass_o !== 1'b0 || data_rd_o !== 32'h0) begin errors++; $display("FAIL reset_bypass got %0b/%08h want 0/0", bypass_o, data_rd_o); end
    checks++; if (addr_o !== 32'h0 || data_wr_o !== 32'h0) begin errors++; $display("FAIL reset_head got %08h/%08h want 0/0", addr_o, data_wr_o); end
    repeat (2) @(posedge clk_i);
    #1 rstn_i = 1;
    load_i = 0;
    tick();
    checks++; if (store_buffer_idx_o !== 2'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", store_buffer_idx_o); end
    checks++; if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin errors++; $display("FAIL idle_after_reset got ready=%0b rsp=%0b want 1/0", req_ready_o, rsp_valid_o); end
    $display("test_reset done");
  endtask

  task automatic test_drain();
    do_reset();
    req_valid_i = 1; addr_i = 32'h1000; data_i = 32'hAAAA_0001;
    #1;
    checks++; if (store_buffer_idx_o !== 2'd0) begin errors++; $display("FAIL drain_alloc_idx got %0d want 0", store_buffer_idx_o); end
    tick();
    req_valid_i = 0;
    store_buffer_commit_i = 1; store_buffer_idx_commit_i = 2'd0;
    #1;
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL drain_before_commit got %0b want 0", rsp_valid_o); end
    tick();
    store_buffer_commit_i = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (rsp_valid_o !== 1'b1 || addr_o !== 32'h1000 || data_wr_o !== 32'hAAAA_0001) begin
        errors++; $display("FAIL drain_hold%0d got v=%0b a=%08h d=%08h want 1/00001000/aaaa0001", c, rsp_valid_o, addr_o, data_wr_o);
      end
      if (c < 3) tick();
    end
    rsp_ready_i = 1;
    tick();
    rsp_ready_i = 0;
    #1;
    checks++; if (rsp_valid_o !== 1'b0 || addr_o !== 32'h0 || data_wr_o !== 32'h0) begin errors++; $display("FAIL drain_after_accept got v=%0b a=%08h d=%08h want 0/0/0", rsp_valid_o, addr_o, data_wr_o); end
    $display("test_drain done");
  endtask

  task automatic test_forward();
    do_reset();
    store(32'h2000, 32'h11);
    store(32'h2000, 32'h22);
    load_i = 1; addr_i = 32'h2000;
    #1;
    checks++; if (bypass_o !== 1'b1 || data_rd_o !== 32'h22) begin errors++; $display("FAIL fwd_youngest got %0b/%08h want 1/00000022", bypass_o, data_rd_o); end
    addr_i = 32'h2003;
    #1;
    checks++; if (bypass_o !== 1'b1 || data_rd_o !== 32'h22) begin errors++; $display("FAIL fwd_same_word got %0b/%08h want 1/00000022", bypass_o, data_rd_o); end
    addr_i = 32'h2004;
    #1;
    checks++; if (bypass_o !== 1'b0 || data_rd_o !== 32'h0) begin errors++; $display("FAIL fwd_next_word got %0b/%08h want 0/0", bypass_o, data_rd_o); end
    load_i = 0; addr_i = 32'h2000;
    #1;
    checks++; if (bypass_o !== 1'b0) begin errors++; $display("FAIL fwd_no_load got %0b want 0", bypass_o); end
    // Store and load to the same new word in one cycle: not visible yet.
    load_i = 1; req_valid_i = 1; addr_i = 32'h3000; data_i = 32'h33;
    #1;
    checks++; if (bypass_o !== 1'b0) begin errors++; $display("FAIL fwd_same_cycle got %0b want 0", bypass_o); end
    tick();
    req_valid_i = 0;
    #1;
    checks++; if (bypass_o !== 1'b1 || data_rd_o !== 32'h33) begin errors++; $display("FAIL fwd_next_cycle got %0b/%08h want 1/00000033", bypass_o, data_rd_o); end
    load_i = 0;
    $display("test_forward done");
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_valid_i = 1; addr_i = 32'h4000 + 32'(4 * i); data_i = 32'h400 + 32'(i);
      #1;
      checks++; if (store_buffer_idx_o !== 2'(i) || req_ready_o !== 1'b1) begin errors++; $display("FAIL fill_idx%0d got idx=%0d rdy=%0b want %0d/1", i, store_buffer_idx_o, req_ready_o, i); end
      tick();
    end
    addr_i = 32'h5000; data_i = 32'hDEAD;
    #1;
    checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got %0b want 0", req_ready_o); end
    tick();
    req_valid_i = 0;
    load_i = 1; addr_i = 32'h5000;
    #1;
    checks++; if (bypass_o !== 1'b0) begin errors++; $display("FAIL full_blocked_store got %0b want 0", bypass_o); end
    load_i = 0;
    store_buffer_commit_i = 1; store_buffer_idx_commit_i = 2'd0;
    tick();
    store_buffer_commit_i = 0;
    rsp_ready_i = 1; req_valid_i = 1; addr_i = 32'h5000; data_i = 32'hBEEF;
    #1;
    checks++; if (rsp_valid_o !== 1'b1 || addr_o !== 32'h4000 || req_ready_o !== 1'b0) begin errors++; $display("FAIL full_pop_no_passthru got v=%0b a=%08h rdy=%0b want 1/00004000/0", rsp_valid_o, addr_o, req_ready_o); end
    tick();
    rsp_ready_i = 0;
    #1;
    checks++; if (req_ready_o !== 1'b1 || store_buffer_idx_o !== 2'd0) begin errors++; $display("FAIL full_wrap got rdy=%0b idx=%0d want 1/0", req_ready_o, store_buffer_idx_o); end
    tick();
    req_valid_i = 0;
    load_i = 1; addr_i = 32'h5000;
    #1;
    checks++; if (store_buffer_idx_o !== 2'd1 || req_ready_o !== 1'b0) begin errors++; $display("FAIL refull got idx=%0d rdy=%0b want 1/0", store_buffer_idx_o, req_ready_o); end
    checks++; if (bypass_o !== 1'b1 || data_rd_o !== 32'hBEEF) begin errors++; $display("FAIL fwd_wrapped got %0b/%08h want 1/0000beef", bypass_o, data_rd_o); end
    addr_i = 32'h4004;
    #1;
    checks++; if (bypass_o !== 1'b1 || data_rd_o !== 32'h401) begin errors++; $display("FAIL fwd_mid got %0b/%08h want 1/00000401", bypass_o, data_rd_o); end
    load_i = 0;
    $display("test_full done");
  endtask

  task automatic test_discard();
    do_reset();
    store(32'h6000, 32'h60);
    store(32'h6004, 32'h61);
    store(32'h6008, 32'h62);
    store_buffer_commit_i = 1; store_buffer_idx_commit_i = 2'd0;
    tick();
    store_buffer_commit_i = 0;
    store_buffer_discard_i = 1;
    #1;
    checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL discard_ready got %0b want 0", req_ready_o); end
    tick();
    store_buffer_discard_i = 0;
    #1;
    checks++; if (store_buffer_idx_o !== 2'd1) begin errors++; $display("FAIL discard_tail got %0d want 1", store_buffer_idx_o); end
    checks++; if (rsp_valid_o !== 1'b1 || addr_o !== 32'h6000 || data_wr_o !== 32'h60) begin errors++; $display("FAIL discard_head got v=%0b a=%08h d=%08h want 1/00006000/00000060", rsp_valid_o, addr_o, data_wr_o); end
    load_i = 1; addr_i = 32'h6008;
    #1;
    checks++; if (bypass_o !== 1'b0) begin errors++; $display("FAIL discard_fwd_dropped got %0b want 0", bypass_o); end
    addr_i = 32'h6000;
    #1;
    checks++; if (bypass_o !== 1'b1 || data_rd_o !== 32'h60) begin errors++; $display("FAIL discard_fwd_kept got %0b/%08h want 1/00000060", bypass_o, data_rd_o); end
    load_i = 0;
    rsp_ready_i = 1;
    tick();
    tick();
    rsp_ready_i = 0;
    #1;
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL discard_only_one_drain got %0b want 0", rsp_valid_o); end
    $display("test_discard done");
  endtask

  task automatic test_commit_discard();
    do_reset();
    store(32'h7000, 32'h70);
    store(32'h7004, 32'h71);
    store(32'h7008, 32'h72);
    store_buffer_commit_i = 1; store_buffer_idx_commit_i = 2'd0;
    tick();
    store_buffer_idx_commit_i = 2'd1;
    store_buffer_discard_i = 1;
    req_valid_i = 1; addr_i = 32'h7100; data_i = 32'h99;
    #1;
    checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL cd_ready got %0b want 0", req_ready_o); end
    tick();
    idle_inputs();
    #1;
    checks++; if (store_buffer_idx_o !== 2'd2) begin errors++; $display("FAIL cd_tail got %0d want 2", store_buffer_idx_o); end
    checks++; if (rsp_valid_o !== 1'b1 || addr_o !== 32'h7000) begin errors++; $display("FAIL cd_drain0 got v=%0b a=%08h want 1/00007000", rsp_valid_o, addr_o); end
    rsp_ready_i = 1;
    tick();
    checks++; if (rsp_valid_o !== 1'b1 || addr_o !== 32'h7004 || data_wr_o !== 32'h71) begin errors++; $display("FAIL cd_drain1 got v=%0b a=%08h d=%08h want 1/00007004/00000071", rsp_valid_o, addr_o, data_wr_o); end
    tick();
    rsp_ready_i = 0;
    load_i = 1; addr_i = 32'h7008;
    #1;
    checks++; if (rsp_valid_o !== 1'b0 || bypass_o !== 1'b0) begin errors++; $display("FAIL cd_empty got v=%0b byp=%0b want 0/0", rsp_valid_o, bypass_o); end
    load_i = 0;
    // Commit to an invalid slot must not pre-commit the next store there.
    store_buffer_commit_i = 1; store_buffer_idx_commit_i = 2'd2;
    tick();
    store_buffer_commit_i = 0;
    store(32'h7200, 32'h77);
    #1;
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL commit_invalid_ignored got %0b want 0", rsp_valid_o); end
    $display("test_commit_discard done");
  endtask

  task automatic test_back_to_back();
    do_reset();
    store(32'h8000, 32'h80);
    req_valid_i = 1; addr_i = 32'h8004; data_i = 32'h81;
    store_buffer_commit_i = 1; store_buffer_idx_commit_i = 2'd0;
    #1;
    checks++; if (store_buffer_idx_o !== 2'd1) begin errors++; $display("FAIL b2b_idx1 got %0d want 1", store_buffer_idx_o); end
    tick();
    addr_i = 32'h8008; data_i = 32'h82;
    store_buffer_idx_commit_i = 2'd1;
    rsp_ready_i = 1;
    #1;
    checks++; if (rsp_valid_o !== 1'b1 || addr_o !== 32'h8000 || store_buffer_idx_o !== 2'd2) begin errors++; $display("FAIL b2b_pop_alloc got v=%0b a=%08h idx=%0d want 1/00008000/2", rsp_valid_o, addr_o, store_buffer_idx_o); end
    tick();
    req_valid_i = 0; store_buffer_commit_i = 0;
    #1;
    checks++; if (rsp_valid_o !== 1'b1 || addr_o !== 32'h8004 || data_wr_o !== 32'h81 || store_buffer_idx_o !== 2'd3) begin errors++; $display("FAIL b2b_second got v=%0b a=%08h d=%08h idx=%0d want 1/00008004/00000081/3", rsp_valid_o, addr_o, data_wr_o, store_buffer_idx_o); end
    tick();
    rsp_ready_i = 0;
    #1;
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_uncommitted_head got %0b want 0", rsp_valid_o); end
    store(32'h800C, 32'h83);
    store(32'h8010, 32'h84);
    store(32'h8014, 32'h85);
    #1;
    checks++; if (req_ready_o !== 1'b0 || store_buffer_idx_o !== 2'd2) begin errors++; $display("FAIL b2b_count got rdy=%0b idx=%0d want 0/2", req_ready_o, store_buffer_idx_o); end
    $display("test_back_to_back done");
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_drain();
    test_forward();
    test_full();
    test_discard();
    test_commit_discard();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
